if_id_fetch: RTL

IF_ID_FETCH -- requirements
Module: if_id_fetch

---
 rtl/if_id_fetch_if.sv | 10 +
 rtl/if_id_fetch.sv | 139 +++++++++++++
 2 files changed

// File: rtl/if_id_fetch_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
interface if_id_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;

  modport master (output imem_req, output imem_addr, input imem_rdata, input imem_ready);
  modport slave  (input imem_req, input imem_addr, output imem_rdata, output imem_ready);
endinterface

// File: rtl/if_id_fetch.sv
// Fetch stage plus IF/ID pipeline register. One request outstanding at a time;
// a skid buffer parks a response that lands during a stall, and DRAIN waits out
// a request that was in flight when a redirect arrived.
`default_nettype none
module if_id_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic        stall,
  input  wire logic        flush,
  input  wire logic [31:0] Branch_Target,
  if_id_fetch_if.master    imem,
  output logic [31:0]      IF_ID_Instr,
  output logic [31:0]      IF_ID_PC4,
  output logic             IF_ID_Valid,
  output logic [4:0]       IF_ID_RegRs,
  output logic [4:0]       IF_ID_RegRt
);

  typedef enum logic [1:0] {FETCH, HOLD, DRAIN} fetchState_t;

  fetchState_t state, stateNxt;
  logic [31:0] pc, pcNxt;
  logic [31:0] fetchAddr, fetchAddrNxt;
  logic [31:0] skidBuf, skidBufNxt;
  logic [31:0] instrQ, instrNxt;
  logic [31:0] pc4Q, pc4Nxt;
  logic        validQ, validNxt;
  logic        reqEn;
  logic [31:0] pcPlus4;
  logic        rsp;

  // No request is driven while in reset; requests start on the first edge after.
  assign imem.imem_req  = reqEn && (state != HOLD);
  assign imem.imem_addr = fetchAddr;

  assign pcPlus4 = pc + 32'd4;
  // A ready with no request outstanding is not a response.
  assign rsp     = imem.imem_ready && imem.imem_req;

  assign IF_ID_Instr = instrQ;
  assign IF_ID_PC4   = pc4Q;
  assign IF_ID_Valid = validQ;
  assign IF_ID_RegRs = instrQ[25:21];
  assign IF_ID_RegRt = instrQ[20:16];

  // Next-state and next-register logic; flush outranks stall and imem_ready.
  always_comb begin
    stateNxt     = state;
    pcNxt        = pc;
    fetchAddrNxt = fetchAddr;
    skidBufNxt   = skidBuf;
    instrNxt     = instrQ;
    pc4Nxt       = pc4Q;
    validNxt     = validQ;
    unique case (state)
      FETCH: begin
        if (flush) begin
          instrNxt   = 32'h0;
          validNxt   = 1'b0;
          pcNxt      = Branch_Target;
          skidBufNxt = 32'h0;
          if (rsp) fetchAddrNxt = Branch_Target;  // response discarded, redirect now
          else     stateNxt     = DRAIN;          // old request still in flight
        end else if (rsp) begin
          if (stall) begin
            skidBufNxt = imem.imem_rdata;
            stateNxt   = HOLD;
          end else begin
            instrNxt     = imem.imem_rdata;
            pc4Nxt       = pcPlus4;
            validNxt     = 1'b1;
            pcNxt        = pcPlus4;
            fetchAddrNxt = pcPlus4;
          end
        end else if (!stall) begin
          instrNxt = 32'h0;
          validNxt = 1'b0;
        end
      end
      HOLD: begin
        if (flush) begin
          instrNxt     = 32'h0;
          validNxt     = 1'b0;
          pcNxt        = Branch_Target;
          fetchAddrNxt = Branch_Target;
          skidBufNxt   = 32'h0;
          stateNxt     = FETCH;
        end else if (!stall) begin
          instrNxt     = skidBuf;
          pc4Nxt       = pcPlus4;
          validNxt     = 1'b1;
          pcNxt        = pcPlus4;
          fetchAddrNxt = pcPlus4;
          stateNxt     = FETCH;
        end
      end
      DRAIN: begin
        // IF/ID stays a bubble until the stale response has been swallowed.
        instrNxt = 32'h0;
        validNxt = 1'b0;
        if (flush) pcNxt = Branch_Target;
        if (rsp) begin
          // A redirect landing on the same cycle as the stale response wins,
          // so fetchAddr never diverges from PC once back in FETCH.
          fetchAddrNxt = flush ? Branch_Target : pc;
          stateNxt     = FETCH;
        end
      end
      default: stateNxt = FETCH;
    endcase
  end

  // State and pipeline registers; reset abandons everything, including DRAIN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      fetchAddr <= RESET_PC;
      skidBuf   <= 32'h0;
      instrQ    <= 32'h0;
      pc4Q      <= 32'h0;
      validQ    <= 1'b0;
      reqEn     <= 1'b0;
    end else begin
      state     <= stateNxt;
      pc        <= pcNxt;
      fetchAddr <= fetchAddrNxt;
      skidBuf   <= skidBufNxt;
      instrQ    <= instrNxt;
      pc4Q      <= pc4Nxt;
      validQ    <= validNxt;
      reqEn     <= 1'b1;
    end
  end

endmodule
`default_nettype wire
